spi_byte_shifter: RTL and testbench

SPI mode-0 byte engine between tx_fifo (upstream) and rx_fifo (downstream) inside the SD card controller.
- Accepts TX bytes through a 1-byte input holding register and drives SCLK/MOSI at a programmable rate.
- Samples MISO and returns captured bytes through a 1-byte output holding register.
- Supports TX-only, RX-burst (autonomous 0xFF fill for a programmed byte count) and full-duplex modes.

---
 rtl/sd_spi_pkg.sv | 31 +++
 rtl/spi_clk_gen.sv | 58 +++++
 rtl/spi_byte_shifter.sv | 185 ++++++++++++++++++
 tb/tb_spi_byte_shifter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_spi_pkg.sv
// Shared constants and helpers for the SD-card SPI byte engine.
// Optional CRC accumulation in spi_byte_shifter is enabled by the
// SPI_SHIFTER_CRC16_EN macro; crc16_step() below is its bit-serial kernel.
package sd_spi_pkg;

  // Default widths for the clock divider and the RX burst counter.
  localparam int SPI_DIV_W = 8;
  localparam int SPI_LEN_W = 13;

  // Transfer modes; the unused encoding 3 behaves like SPI_MODE_TX.
  localparam logic [1:0] SPI_MODE_TX     = 2'd0;
  localparam logic [1:0] SPI_MODE_RX     = 2'd1;
  localparam logic [1:0] SPI_MODE_DUPLEX = 2'd2;

  // Byte driven on MOSI during autonomous RX bursts.
  localparam logic [7:0] IDLE_MOSI = 8'hFF;

  // CRC-16-CCITT generator polynomial (x^16 + x^12 + x^5 + 1).
  localparam logic [15:0] CRC16_POLY = 16'h1021;

  // One MSB-first step of CRC-16-CCITT for a single received bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    crc16_step = {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? CRC16_POLY : 16'h0000);
  endfunction

  // Modes in which received bits are kept and delivered.
  function automatic logic is_capture_mode(input logic [1:0] mode);
    is_capture_mode = (mode == SPI_MODE_RX) || (mode == SPI_MODE_DUPLEX);
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: a half-period counter that toggles SCLK every
// i_div+1 clk cycles while running, and flags the cycle before each
// edge with a one-cycle o_rise / o_fall strobe. i_start (re)arms it with
// SCLK low and latches the divider; i_stop parks it with SCLK low.
module spi_clk_gen
  import sd_spi_pkg::*;
#(
  parameter int DIV_W = SPI_DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_rise,
  output logic             o_fall,
  output logic             o_sclk
);

  logic             r_run;
  logic             r_sclk;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;
  logic             w_tick;

  // The half-period has elapsed: SCLK toggles on the coming edge.
  assign w_tick = r_run && (r_cnt == r_div);
  assign o_rise = w_tick && !r_sclk;
  assign o_fall = w_tick &&  r_sclk;
  assign o_sclk = r_sclk;

  // Half-period counter and SCLK level; start wins over stop wins over tick.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_run  <= 1'b0;
      r_sclk <= 1'b0;
      r_div  <= '0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_run  <= 1'b1;
      r_sclk <= 1'b0;
      r_div  <= i_div;
      r_cnt  <= '0;
    end else if (i_stop) begin
      r_run  <= 1'b0;
      r_sclk <= 1'b0;
      r_cnt  <= '0;
    end else if (w_tick) begin
      r_sclk <= ~r_sclk;
      r_cnt  <= '0;
    end else if (r_run) begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_byte_shifter.sv
// SPI mode-0 byte engine between tx_fifo and rx_fifo of the SD controller.
// One-byte input and output holding registers, TX-only / RX-burst /
// full-duplex modes, SCLK half-period = clk_div+1 cycles.
// Define SPI_SHIFTER_CRC16_EN to accumulate CRC-16-CCITT over sampled MISO
// bits; otherwise crc16 is tied to zero.
module spi_byte_shifter
  import sd_spi_pkg::*;
#(
  parameter int DIV_W = SPI_DIV_W,
  parameter int LEN_W = SPI_LEN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] clk_div,
  input  logic [1:0]       mode,
  input  logic [LEN_W-1:0] new_rx_length,
  input  logic             set_rx_length,
  input  logic             wr_req,
  input  logic             rd_req,
  input  logic [7:0]       data_in,
  output logic [7:0]       data_out,
  output logic             in_full,
  output logic             out_full,
  output logic             busy,
  input  logic             MISO,
  output logic             MOSI,
  output logic             SCLK,
  output logic [15:0]      crc16
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_tx;
  logic [7:0]       r_rx;
  logic             r_cap;
  logic [7:0]       r_in_data;
  logic             r_in_full;
  logic [7:0]       r_out_data;
  logic             r_out_full;
  logic [LEN_W-1:0] r_rx_cnt;

  logic             w_idle;
  logic             w_mode_cap;
  logic             w_start_tx;
  logic             w_start_rx;
  logic             w_start;
  logic [7:0]       w_start_byte;
  logic             w_rise;
  logic             w_fall;
  logic             w_sclk;
  logic             w_last_fall;
  logic             w_deliver;

  // Start decision: TX-type modes consume the input register, RX burst
  // sends 0xFF while the counter is non-zero; capturing modes stall while
  // the previous byte is still unread.
  assign w_idle       = (r_state == ST_IDLE);
  assign w_mode_cap   = is_capture_mode(mode);
  assign w_start_tx   = w_idle && (mode != SPI_MODE_RX) && r_in_full &&
                        !(w_mode_cap && r_out_full);
  assign w_start_rx   = w_idle && (mode == SPI_MODE_RX) && (r_rx_cnt != '0) &&
                        !r_out_full;
  assign w_start      = w_start_tx || w_start_rx;
  assign w_start_byte = w_start_rx ? IDLE_MOSI : r_in_data;
  assign w_last_fall  = (r_state == ST_SHIFT) && w_fall && (r_bit_idx == 3'd0);
  assign w_deliver    = (r_state == ST_DONE) && r_cap;

  spi_clk_gen #(
    .DIV_W (DIV_W)
  ) u_clk_gen (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_start),
    .i_stop  (w_last_fall),
    .i_div   (clk_div),
    .o_rise  (w_rise),
    .o_fall  (w_fall),
    .o_sclk  (w_sclk)
  );

  // Byte FSM: latch the byte at start, sample MISO on rises, shift MOSI on falls.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_bit_idx <= 3'd0;
      r_tx      <= IDLE_MOSI;
      r_rx      <= 8'h00;
      r_cap     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state   <= ST_SHIFT;
            r_bit_idx <= 3'd7;
            r_tx      <= w_start_byte;
            r_cap     <= w_mode_cap;
          end
        end
        ST_SHIFT: begin
          if (w_rise) begin
            r_rx <= {r_rx[6:0], MISO};
          end
          if (w_fall) begin
            if (r_bit_idx == 3'd0) begin
              r_state <= ST_DONE;
            end else begin
              r_bit_idx <= r_bit_idx - 1'b1;
              r_tx      <= {r_tx[6:0], 1'b1};
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Input holding register; a write while occupied is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_full <= 1'b0;
      r_in_data <= 8'h00;
    end else if (w_start_tx) begin
      r_in_full <= 1'b0;
    end else if (wr_req && !r_in_full) begin
      r_in_full <= 1'b1;
      r_in_data <= data_in;
    end
  end

  // Output holding register; a completing capture overrides a same-cycle read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_full <= 1'b0;
      r_out_data <= 8'h00;
    end else if (w_deliver) begin
      r_out_full <= 1'b1;
      r_out_data <= r_rx;
    end else if (rd_req) begin
      r_out_full <= 1'b0;
    end
  end

  // RX burst counter; a host load overrides the start-of-byte decrement.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_cnt <= '0;
    end else if (set_rx_length) begin
      r_rx_cnt <= new_rx_length;
    end else if (w_start_rx) begin
      r_rx_cnt <= r_rx_cnt - 1'b1;
    end
  end

`ifdef SPI_SHIFTER_CRC16_EN
  logic [15:0] r_crc;

  // Running CRC over every bit sampled in a capturing byte.
  always_ff @(posedge clk) begin
    if (reset || set_rx_length) begin
      r_crc <= 16'h0000;
    end else if ((r_state == ST_SHIFT) && w_rise && r_cap) begin
      r_crc <= crc16_step(r_crc, MISO);
    end
  end

  assign crc16 = r_crc;
`else
  assign crc16 = 16'h0000;
`endif

  // NOTE: reset also gates the pins combinationally so an abort parks SCLK
  // low and MOSI high in the very cycle reset is asserted.
  assign SCLK     = w_sclk && !reset;
  assign MOSI     = reset || (r_state != ST_SHIFT) || r_tx[7];
  assign busy     = (r_state != ST_IDLE) || r_in_full || (r_rx_cnt != '0);
  assign in_full  = r_in_full;
  assign out_full = r_out_full;
  assign data_out = r_out_data;

endmodule

// File: tb/tb_spi_byte_shifter.sv
// Directed bench for spi_byte_shifter: a vector table of single-byte
// transfers plus hand-written burst, stall, reset-abort, cancel and CRC
// sequences. A small slave model drives MISO (changing after each SCLK fall)
// and records MOSI at each SCLK rise.
module tb_spi_byte_shifter;
  import sd_spi_pkg::*;

  localparam int DIV_W = 8;
  localparam int LEN_W = 13;

  logic             clk = 1'b0;
  logic             reset;
  logic [DIV_W-1:0] clk_div;
  logic [1:0]       mode;
  logic [LEN_W-1:0] new_rx_length;
  logic             set_rx_length;
  logic             wr_req;
  logic             rd_req;
  logic [7:0]       data_in;
  logic [7:0]       data_out;
  logic             in_full;
  logic             out_full;
  logic             busy;
  logic             MISO;
  logic             MOSI;
  logic             SCLK;
  logic [15:0]      crc16;

  int n_cmp = 0;
  int n_err = 0;

  spi_byte_shifter #(
    .DIV_W (DIV_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .clk_div       (clk_div),
    .mode          (mode),
    .new_rx_length (new_rx_length),
    .set_rx_length (set_rx_length),
    .wr_req        (wr_req),
    .rd_req        (rd_req),
    .data_in       (data_in),
    .data_out      (data_out),
    .in_full       (in_full),
    .out_full      (out_full),
    .busy          (busy),
    .MISO          (MISO),
    .MOSI          (MOSI),
    .SCLK          (SCLK),
    .crc16         (crc16)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] div;
    logic [7:0] txd;
    logic [7:0] miso;
    logic [7:0] exp_mosi;
    logic       exp_full;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 ns after the edge; outputs are read at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Follow one byte from the current cycle until the 8th SCLK fall.
  // Returns the MOSI byte seen at the rises, the rise count, and the span in
  // cycles from the first rise to the 8th fall. Optionally pulses
  // set_rx_length with length 0 right after the 3rd rise.
  task automatic run_byte(input logic [7:0] miso_b, input int div, input bit do_cancel,
                          output logic [7:0] mosi_b, output int rises, output int span);
    logic [7:0] sh;
    logic       prev;
    int         falls;
    int         t;
    int         t_first;
    bit         cancel_pending;
    sh = miso_b;
    MISO = sh[7];
    mosi_b = 8'h00;
    rises = 0;
    falls = 0;
    span = 0;
    t = 0;
    t_first = 0;
    cancel_pending = 1'b0;
    prev = SCLK;
    while ((falls < 8) && (t < 40 * (div + 1) + 200)) begin
      tick();
      t++;
      if (cancel_pending) begin
        set_rx_length = 1'b0;
        cancel_pending = 1'b0;
      end
      if (SCLK && !prev) begin
        mosi_b = {mosi_b[6:0], MOSI};
        rises++;
        if (rises == 1) t_first = t;
        if (do_cancel && rises == 3) begin
          new_rx_length = '0;
          set_rx_length = 1'b1;
          cancel_pending = 1'b1;
        end
      end
      if (!SCLK && prev) begin
        falls++;
        sh = {sh[6:0], 1'b1};
        MISO = (falls < 8) ? sh[7] : 1'b1;
        if (falls == 8) span = t - t_first;
      end
      prev = SCLK;
    end
    if (cancel_pending) set_rx_length = 1'b0;
    if (falls < 8) check("byte_timeout_falls", falls, 8);
  endtask

  // Count cycles with SCLK high over a window.
  task automatic idle_window(input int cycles, output int highs);
    highs = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (SCLK) highs++;
    end
  endtask

  task automatic read_out();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] mosi_b;
    int         rises;
    int         span;
    int         highs;
    logic [15:0] exp_crc;

    //            mode             div    txd    miso   mosi   full  dout
    vecs[0] = '{SPI_MODE_TX,     8'd0, 8'hA5, 8'h5A, 8'hA5, 1'b0, 8'h00};
    vecs[1] = '{SPI_MODE_DUPLEX, 8'd1, 8'h3C, 8'hC3, 8'h3C, 1'b1, 8'hC3};
    vecs[2] = '{SPI_MODE_RX,     8'd3, 8'h00, 8'h96, 8'hFF, 1'b1, 8'h96};
    vecs[3] = '{2'd3,            8'd2, 8'h81, 8'h7E, 8'h81, 1'b0, 8'h00};
    vecs[4] = '{SPI_MODE_DUPLEX, 8'd0, 8'h00, 8'hFF, 8'h00, 1'b1, 8'hFF};
    vecs[5] = '{SPI_MODE_RX,     8'd0, 8'h12, 8'h00, 8'hFF, 1'b1, 8'h00};

    reset = 1'b1;
    clk_div = '0;
    mode = SPI_MODE_TX;
    new_rx_length = '0;
    set_rx_length = 1'b0;
    wr_req = 1'b0;
    rd_req = 1'b0;
    data_in = 8'h00;
    MISO = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("rst_sclk", SCLK, 1'b0);
    check("rst_mosi", MOSI, 1'b1);
    check("rst_in_full", in_full, 1'b0);
    check("rst_out_full", out_full, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_data_out", data_out, 8'h00);
    check("rst_crc16", crc16, 16'h0000);

    // ---------------- table-driven single bytes ----------------
    for (int v = 0; v < 6; v++) begin
      mode = vecs[v].mode;
      clk_div = vecs[v].div;
      if (vecs[v].mode == SPI_MODE_RX) begin
        new_rx_length = 13'd1;
        set_rx_length = 1'b1;
        tick();
        set_rx_length = 1'b0;
      end else begin
        data_in = vecs[v].txd;
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
      end
      check($sformatf("v%0d_busy_start", v), busy, 1'b1);
      run_byte(vecs[v].miso, int'(vecs[v].div), 1'b0, mosi_b, rises, span);
      check($sformatf("v%0d_mosi", v), mosi_b, vecs[v].exp_mosi);
      check($sformatf("v%0d_rises", v), rises, 8);
      check($sformatf("v%0d_span", v), span, 15 * (int'(vecs[v].div) + 1));
      check($sformatf("v%0d_busy_done", v), busy, 1'b1);
      tick();
      check($sformatf("v%0d_out_full", v), out_full, vecs[v].exp_full);
      check($sformatf("v%0d_busy_after", v), busy, 1'b0);
      check($sformatf("v%0d_mosi_idle", v), MOSI, 1'b1);
      if (vecs[v].exp_full) begin
        check($sformatf("v%0d_data_out", v), data_out, vecs[v].exp_dout);
        read_out();
        check($sformatf("v%0d_out_cleared", v), out_full, 1'b0);
      end
    end

    // ---------------- RX burst of 3, clk_div=3 ----------------
    mode = SPI_MODE_RX;
    clk_div = 8'd3;
    new_rx_length = 13'd3;
    set_rx_length = 1'b1;
    tick();
    set_rx_length = 1'b0;
    for (int b = 0; b < 3; b++) begin
      logic [7:0] pat;
      pat = (b == 0) ? 8'h3C : ((b == 1) ? 8'h00 : 8'hFF);
      run_byte(pat, 3, 1'b0, mosi_b, rises, span);
      check($sformatf("burst%0d_mosi", b), mosi_b, 8'hFF);
      check($sformatf("burst%0d_span", b), span, 60);
      tick();
      check($sformatf("burst%0d_out_full", b), out_full, 1'b1);
      check($sformatf("burst%0d_data", b), data_out, pat);
      read_out();
    end
    tick();
    check("burst_busy_end", busy, 1'b0);

    // ---------------- duplex stall while out_full ----------------
    mode = SPI_MODE_DUPLEX;
    clk_div = 8'd0;
    data_in = 8'h11;
    wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    run_byte(8'hAA, 0, 1'b0, mosi_b, rises, span);
    check("stall_b1_mosi", mosi_b, 8'h11);
    tick();
    check("stall_b1_full", out_full, 1'b1);
    data_in = 8'h22;
    wr_req = 1'b1;
    tick();
    data_in = 8'h99;
    tick();
    wr_req = 1'b0;
    idle_window(20, highs);
    check("stall_sclk_highs", highs, 0);
    check("stall_in_full", in_full, 1'b1);
    check("stall_busy", busy, 1'b1);
    check("stall_data_held", data_out, 8'hAA);
    read_out();
    run_byte(8'h55, 0, 1'b0, mosi_b, rises, span);
    check("stall_b2_mosi", mosi_b, 8'h22);
    check("stall_b2_rises", rises, 8);
    tick();
    check("stall_b2_full", out_full, 1'b1);
    check("stall_b2_data", data_out, 8'h55);
    read_out();

    // ---------------- reset mid-byte (bit 4) ----------------
    mode = SPI_MODE_DUPLEX;
    clk_div = 8'd1;
    data_in = 8'hF0;
    wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    begin
      logic prev;
      int   r;
      int   t;
      prev = SCLK;
      r = 0;
      t = 0;
      while (r < 4 && t < 200) begin
        tick();
        t++;
        if (SCLK && !prev) r++;
        prev = SCLK;
      end
      check("abort_reached_bit4", r, 4);
    end
    data_in = 8'h77;
    wr_req = 1'b1;
    reset = 1'b1;
    #1;
    check("abort_sclk_same_cycle", SCLK, 1'b0);
    tick();
    wr_req = 1'b0;
    check("abort_sclk", SCLK, 1'b0);
    check("abort_mosi", MOSI, 1'b1);
    check("abort_in_full", in_full, 1'b0);
    check("abort_out_full", out_full, 1'b0);
    check("abort_busy", busy, 1'b0);
    reset = 1'b0;
    idle_window(40, highs);
    check("abort_no_restart", highs, 0);
    check("abort_no_delivery", out_full, 1'b0);
    check("abort_data_out", data_out, 8'h00);

    // ---------------- cancel burst during byte 2 ----------------
    mode = SPI_MODE_RX;
    clk_div = 8'd0;
    new_rx_length = 13'd5;
    set_rx_length = 1'b1;
    tick();
    set_rx_length = 1'b0;
    run_byte(8'hC5, 0, 1'b0, mosi_b, rises, span);
    tick();
    check("cancel_b1_data", data_out, 8'hC5);
    read_out();
    run_byte(8'h69, 0, 1'b1, mosi_b, rises, span);
    check("cancel_b2_rises", rises, 8);
    tick();
    check("cancel_b2_full", out_full, 1'b1);
    check("cancel_b2_data", data_out, 8'h69);
    check("cancel_busy", busy, 1'b0);
    read_out();
    idle_window(50, highs);
    check("cancel_no_more_bytes", highs, 0);
    check("cancel_out_empty", out_full, 1'b0);

    // ---------------- CRC over "123456789" ----------------
    mode = SPI_MODE_RX;
    clk_div = 8'd0;
    new_rx_length = 13'd9;
    set_rx_length = 1'b1;
    tick();
    set_rx_length = 1'b0;
    for (int b = 0; b < 9; b++) begin
      logic [7:0] ch;
      ch = 8'h31 + 8'(b);
      run_byte(ch, 0, 1'b0, mosi_b, rises, span);
      tick();
      check($sformatf("crc_byte%0d", b), data_out, ch);
      read_out();
    end
`ifdef SPI_SHIFTER_CRC16_EN
    exp_crc = 16'h31C3;
`else
    exp_crc = 16'h0000;
`endif
    check("crc16_123456789", crc16, exp_crc);
    check("crc_busy_end", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
